// File: rtl/ioports_uart.sv
// ioports_uart: 8N1 serial front end for the 32-bit I/O port block.
// Full-duplex RX/TX channels sharing one baud divisor, no shared state.
module ioports_uart #(
  parameter int BAUD_DIV = 868,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic       load,
  output logic [7:0] rxbyte,
  output logic       frame_err,
  output logic       ready,
  input  logic       enout,
  input  logic [7:0] txbyte,
  output logic       rx_busy,
  output logic       tx_busy
);
  localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_HOLD
  } tx_state_t;

  logic        rx_meta, rs;
  rx_state_t   rx_st, rx_nx;
  logic [15:0] rx_cnt, rx_cnt_nx;
  logic [7:0]  rx_sh, rx_sh_nx, rxbyte_nx;
  logic [2:0]  rx_bit, rx_bit_nx;
  logic        load_nx, ferr_nx, rx_tick;

  tx_state_t   tx_st, tx_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [7:0]  tx_sh, tx_sh_nx;
  logic [2:0]  tx_bit, tx_bit_nx;
  logic        txd_nx, ready_nx, tx_tick;

  assign rx_tick = (rx_cnt == 16'd0);
  assign tx_tick = (tx_cnt == 16'd0);
  assign rx_busy = (rx_st != RX_IDLE);
  assign tx_busy = (tx_st != TX_IDLE);

  // rxd is asynchronous; idle-high reset value avoids a false start
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rs      <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st     <= RX_IDLE;
      rx_cnt    <= 16'd0;
      rx_sh     <= 8'h00;
      rx_bit    <= 3'd0;
      rxbyte    <= 8'h00;
      load      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_st     <= rx_nx;
      rx_cnt    <= rx_cnt_nx;
      rx_sh     <= rx_sh_nx;
      rx_bit    <= rx_bit_nx;
      rxbyte    <= rxbyte_nx;
      load      <= load_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    rx_nx     = rx_st;
    rx_cnt_nx = rx_tick ? BAUD_M1 : rx_cnt - 16'd1;
    rx_sh_nx  = rx_sh;
    rx_bit_nx = rx_bit;
    rxbyte_nx = rxbyte;
    load_nx   = 1'b0;
    ferr_nx   = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        if (!rs) begin
          rx_nx     = RX_START;
          rx_cnt_nx = HALF_M1;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_bit_nx = 3'd0;
          rx_nx     = rs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_sh_nx  = {rs, rx_sh[7:1]};
          rx_bit_nx = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          if (rs) begin
            rxbyte_nx = rx_sh;
            load_nx   = 1'b1;
            rx_nx     = RX_IDLE;
          end else begin
            ferr_nx = 1'b1;
            rx_nx   = RX_WAITHI;
          end
        end
      end
      RX_WAITHI: begin
        if (rs) rx_nx = RX_IDLE;
      end
      default: rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= 16'd0;
      tx_sh  <= 8'h00;
      tx_bit <= 3'd0;
      txd    <= 1'b1;
      ready  <= 1'b1;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= tx_cnt_nx;
      tx_sh  <= tx_sh_nx;
      tx_bit <= tx_bit_nx;
      txd    <= txd_nx;
      ready  <= ready_nx;
    end
  end

  // txd is registered, so each bit is set up one cycle ahead at the tick
  always_comb begin
    tx_nx     = tx_st;
    tx_cnt_nx = tx_tick ? BAUD_M1 : tx_cnt - 16'd1;
    tx_sh_nx  = tx_sh;
    tx_bit_nx = tx_bit;
    txd_nx    = txd;
    ready_nx  = ready;
    unique case (tx_st)
      TX_IDLE: begin
        txd_nx   = 1'b1;
        ready_nx = 1'b1;
        if (enout) begin
          tx_sh_nx  = txbyte;
          txd_nx    = 1'b0;
          ready_nx  = 1'b0;
          tx_cnt_nx = BAUD_M1;
          tx_nx     = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          txd_nx    = tx_sh[0];
          tx_sh_nx  = {1'b0, tx_sh[7:1]};
          tx_bit_nx = 3'd0;
          tx_nx     = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            txd_nx = 1'b1;
            tx_nx  = TX_STOP;
          end else begin
            txd_nx    = tx_sh[0];
            tx_sh_nx  = {1'b0, tx_sh[7:1]};
            tx_bit_nx = tx_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (enout) begin
            tx_nx = TX_HOLD;
          end else begin
            ready_nx = 1'b1;
            tx_nx    = TX_IDLE;
          end
        end
      end
      TX_HOLD: begin
        if (!enout) begin
          ready_nx = 1'b1;
          tx_nx    = TX_IDLE;
        end
      end
      default: tx_nx = TX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ioports_uart.sv
// tb_ioports_uart: scoreboard bench for ioports_uart at BAUD_DIV=16.
// Stimulus pushes expected RX events / TX bytes; monitors pop and compare.
module tb_ioports_uart;
  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       txd;
  logic       load;
  logic [7:0] rxbyte;
  logic       frame_err;
  logic       ready;
  logic       enout;
  logic [7:0] txbyte;
  logic       rx_busy;
  logic       tx_busy;

  typedef struct {
    logic       ferr;
    logic [7:0] b;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  logic [7:0] tx_q[$];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int load_cyc = 0;

  ioports_uart #(.BAUD_DIV(16)) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .txd(txd),
    .load(load),
    .rxbyte(rxbyte),
    .frame_err(frame_err),
    .ready(ready),
    .enout(enout),
    .txbyte(txbyte),
    .rx_busy(rx_busy),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input logic v, input int lim, input string name);
    int n;
    n = 0;
    while (ready !== v && n < lim) begin
      cyc_n(1);
      n++;
    end
    if (ready !== v) begin
      vecs++;
      errs++;
      $display("FAIL %s: timeout, ready=%b want %b", name, ready, v);
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stopb);
    rxd = 1'b0;
    fall_cyc = cyc;
    cyc_n(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc_n(16);
    end
    rxd = stopb;
    cyc_n(16);
  endtask

  task automatic tx_send(input logic [7:0] b);
    wait_ready(1'b1, 400, "tx_ready_hi");
    txbyte = b;
    tx_q.push_back(b);
    enout = 1'b1;
    wait_ready(1'b0, 4, "tx_ready_lo");
    cyc_n(1);
    enout = 1'b0;
  endtask

  // RX monitor: every load or frame_err pulse must match the queue head
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (load || frame_err)) begin
        if (load) load_cyc = cyc;
        if (rx_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL rx_unexpected: load=%b frame_err=%b rxbyte=%h",
                   load, frame_err, rxbyte);
        end else begin
          e = rx_q.pop_front();
          check("rx_kind_ferr", {31'd0, frame_err}, {31'd0, e.ferr});
          check("rx_kind_load", {31'd0, load}, {31'd0, !e.ferr});
          check("rxbyte", {24'd0, rxbyte}, {24'd0, e.b});
        end
      end
    end
  end

  // TX monitor: each start bit opens a 160-cycle window checked per cycle
  initial begin : tx_mon
    logic [9:0] fr;
    logic [7:0] eb;
    int bad;
    bit abort;
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        if (tx_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL tx_unexpected: start bit with empty queue");
          repeat (159) @(negedge clk);
        end else begin
          eb = tx_q.pop_front();
          fr = {1'b1, eb, 1'b0};
          bad = 0;
          abort = 1'b0;
          for (int i = 0; i < 160 && !abort; i++) begin
            if (i > 0) @(negedge clk);
            if (reset) abort = 1'b1;
            else if (txd !== fr[i/16]) bad++;
          end
          if (!abort) begin
            vecs++;
            if (bad != 0) begin
              errs++;
              $display("FAIL tx_frame %h: %0d bad cycles, want 0", eb, bad);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int lowcnt;
    reset = 1'b1;
    rxd = 1'b1;
    enout = 1'b0;
    txbyte = 8'h00;
    cyc_n(3);
    reset = 1'b0;
    cyc_n(1);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_rxbyte", {24'd0, rxbyte}, 32'h00);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    cyc_n(5);

    // good frame 0x25, load 155 cycles after the falling edge
    rx_q.push_back('{1'b0, 8'h25});
    load_cyc = -1;
    rx_frame(8'h25, 1'b1);
    cyc_n(4);
    lat = load_cyc - fall_cyc;
    vecs++;
    if (lat < 154 || lat > 156) begin
      errs++;
      $display("FAIL rx_latency: got %0d want 154..156", lat);
    end

    // 5-cycle glitch is rejected
    rxd = 1'b0;
    cyc_n(5);
    rxd = 1'b1;
    check("glitch_busy", {31'd0, rx_busy}, 32'd1);
    cyc_n(7);
    check("glitch_idle", {31'd0, rx_busy}, 32'd0);
    cyc_n(10);

    // 0x81 with low stop bit, then a break
    rx_q.push_back('{1'b1, 8'h25});
    rx_frame(8'h81, 1'b0);
    cyc_n(100);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    cyc_n(4);
    check("break_idle", {31'd0, rx_busy}, 32'd0);
    check("break_rxbyte", {24'd0, rxbyte}, 32'h25);
    cyc_n(10);

    // TX 0xA5: ready low for exactly one frame
    txbyte = 8'hA5;
    tx_q.push_back(8'hA5);
    enout = 1'b1;
    wait_ready(1'b0, 4, "a5_ready_lo");
    lowcnt = 1;
    for (int i = 0; i < 400; i++) begin
      cyc_n(1);
      if (i == 0) enout = 1'b0;
      if (ready) break;
      lowcnt++;
    end
    check("a5_ready_low", lowcnt, 32'd160);
    check("a5_tx_idle", {31'd0, tx_busy}, 32'd0);
    cyc_n(10);

    // held enout: one frame, ready waits for enout to drop
    txbyte = 8'h3C;
    tx_q.push_back(8'h3C);
    enout = 1'b1;
    cyc_n(300);
    check("hold_ready", {31'd0, ready}, 32'd0);
    check("hold_busy", {31'd0, tx_busy}, 32'd1);
    enout = 1'b0;
    cyc_n(1);
    check("hold_release", {31'd0, ready}, 32'd1);
    cyc_n(10);

    // full duplex: receive 0x3F while returning four bytes
    rx_q.push_back('{1'b0, 8'h3F});
    fork
      rx_frame(8'h3F, 1'b1);
      begin
        tx_send(8'h20);
        tx_send(8'h19);
        tx_send(8'h20);
        tx_send(8'h20);
      end
    join
    wait_ready(1'b1, 400, "dup_ready_hi");
    check("dup_rxbyte", {24'd0, rxbyte}, 32'h3F);

    // reset during the low bit 3 of 0x55
    tx_send(8'h55);
    cyc_n(70);
    check("pre_rst_txd", {31'd0, txd}, 32'd0);
    check("pre_rst_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    cyc_n(1);
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_rxbyte", {24'd0, rxbyte}, 32'h00);
    reset = 1'b0;
    cyc_n(200);

    check("rx_q_empty", rx_q.size(), 32'd0);
    check("tx_q_empty", tx_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ioports_uart.md
Name: ioports_uart

Overview:
- Serial front end that sits directly upstream of the 32-bit I/O port block.
- Receives 8N1 UART bytes from the host and presents each byte as a one-cycle load pulse on an 8-bit bus.
- Transmits the port block's read-back bytes using the port block's ready/enout handshake.
- RX and TX are independent full-duplex channels sharing one baud parameter.

Parameters:
- BAUD_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range 16..65535.
- HALF_DIV, BAUD_DIV/2, cycles from detected start edge to the start-bit check point.

Ports:
- clk  input  1  master clock
- reset  input  1  master reset
- rxd  input  1  asynchronous serial input, idle high
- txd  output  1  serial output, idle high
- load  output  1  one-cycle pulse: rxbyte valid (drives port block load)
- rxbyte  output  8  last received byte (drives port block datain)
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- ready  output  1  transmitter can accept a byte (drives port block ready)
- enout  input  1  byte on txbyte valid, held high until ready falls
- txbyte  input  8  byte to send (from port block dataout)
- rx_busy  output  1  RX state machine not in RX_IDLE
- tx_busy  output  1  TX state machine not in TX_IDLE

Interface rules:
- One clock; reset is synchronous and active-high.
- Ports are named clk and reset.

Behaviour:
- Reset values: txd=1, load=0, rxbyte=0x00, frame_err=0, ready=1, rx_busy=0, tx_busy=0.
- Reset clears both state machines, both counters and both shift registers.
- Reset mid-frame aborts the frame: txd=1 and ready=1 from the first cycle after reset.
- rxd passes through a 2-FF synchronizer (reset value 1). All RX decisions use the synchronized value rs.
- Each channel has a 16-bit down-counter; "tick" means counter==0, and the counter reloads on every tick.
- RX states:
  - RX_IDLE: rs==0 -> RX_START, counter=HALF_DIV-1.
  - RX_START: at tick, rs==0 -> RX_DATA, counter=BAUD_DIV-1, bitcnt=0. At tick, rs==1 -> RX_IDLE (glitch rejected, no output).
  - RX_DATA: at each tick, shift rs in LSB-first. After the 8th sample -> RX_STOP.
  - RX_STOP: at tick, rs==1 -> rxbyte<=shift and load=1 for exactly one cycle (the cycle after the tick), then RX_IDLE.
  - RX_STOP: at tick, rs==0 -> frame_err=1 for one cycle, rxbyte unchanged, then RX_WAITHI.
  - RX_WAITHI: stay until rs==1 -> RX_IDLE (a break condition yields one frame_err only).
- rxbyte holds its value until the next valid byte; there is no overrun state.
- TX states:
  - TX_IDLE: ready=1, txd=1. enout==1 -> latch txbyte, ready=0, txd=0 (start bit) on the next cycle, counter=BAUD_DIV-1, state TX_START.
  - TX_START -> TX_DATA: 8 bits LSB-first, each exactly BAUD_DIV cycles.
  - TX_DATA -> TX_STOP: txd=1 for BAUD_DIV cycles.
  - After TX_STOP: enout==0 -> TX_IDLE with ready=1 the following cycle. enout==1 -> TX_HOLD.
  - TX_HOLD: ready=0 until enout==0, then TX_IDLE. A held enout never starts a second frame.
- ready is low from the cycle after enout is accepted until the frame is complete and enout has been seen low.
- Total frame length on txd is exactly 10*BAUD_DIV cycles.
- Simultaneous RX and TX activity is fully independent, with no shared state.
- txd, ready, load and frame_err are registered outputs with no combinational path from inputs.

Test Plan:
- BAUD_DIV=16; drive rxd frame for 0x25 -> exactly one load pulse, rxbyte=0x25, load 2+8+144+1 cycles after the falling edge (±1); frame_err stays 0.
- BAUD_DIV=16; rxd low pulse of 5 cycles -> no load, no frame_err, rx_busy back to 0 within 12 cycles.
- BAUD_DIV=16; frame 0x81 with stop bit 0, then rxd held low 100 cycles, then high -> one frame_err pulse, no load, rxbyte unchanged, RX returns to idle after rxd rises.
- BAUD_DIV=16; enout=1 with txbyte=0xA5, dropped 1 cycle after ready falls -> txd sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles; ready low for 160 cycles, then 1.
- BAUD_DIV=16; enout held high 300 cycles -> single frame only; ready stays 0 until the cycle after enout falls.
- Integration with the port block: send bytes 0x3F, then return ready/enout bytes -> txd carries 0x20, 0x19, 0x20, 0x20 in order. Reset asserted mid-transmission -> txd=1 and ready=1 the next cycle.
